// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
package wb_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        WRITE     = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: picks the addressed byte/half/word out of a
// word-aligned read and extends it; flags misaligned or illegal load types.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      func3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data,
    output logic            misalign,
    output logic            illegal
);

    function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] b);
        return XLEN'(b);
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] h);
        return XLEN'(h);
    endfunction

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = '0;
        case (func3)
            F3_LB:   data = sext8(byte_sel);
            F3_LBU:  data = XLEN'(byte_sel);
            F3_LH:   data = sext16(half_sel);
            F3_LHU:  data = XLEN'(half_sel);
            F3_LW:   data = rdata;
            default: data = '0;
        endcase
    end

    always_comb begin
        misalign = (((func3 == F3_LH) || (func3 == F3_LHU)) && addr_lo[0])
                 || ((func3 == F3_LW) && (addr_lo != 2'b00));
        illegal  = !((func3 == F3_LB) || (func3 == F3_LH) || (func3 == F3_LW)
                  || (func3 == F3_LBU) || (func3 == F3_LHU));
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires MEM ops into the register-file write port.
// Define WB_FWD_EN to expose the forwarding/hazard outputs.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_we,
    input  logic            in_is_load,
    input  logic [4:0]      in_rd,
    input  logic [2:0]      in_func3,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_result,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            RegWe,
    output logic [4:0]      RegWr,
    output logic [XLEN-1:0] RegWd,
    output logic            load_err
`ifdef WB_FWD_EN
    ,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            wait_load
`endif
);

    wb_state_t       state, state_nx;

    logic            op_we;
    logic [4:0]      op_rd;
    logic [2:0]      op_func3;
    logic [1:0]      op_addr_lo;

    logic [7:0]      tmo_cnt, tmo_cnt_nx;
    logic            reg_we_nx, load_err_nx;
    logic [4:0]      reg_wr_nx;
    logic [XLEN-1:0] reg_wd_nx;

    logic [XLEN-1:0] align_data;
    logic            align_misalign, align_illegal;
    logic            accept, timed_out;

    assign in_ready  = (state != WAIT_LOAD);
    assign accept    = in_valid & in_ready;
    assign timed_out = (tmo_cnt == 8'(LOAD_TIMEOUT - 1));

    load_align #(.XLEN(XLEN)) u_align (
        .rdata    (dmem_rdata),
        .func3    (op_func3),
        .addr_lo  (op_addr_lo),
        .data     (align_data),
        .misalign (align_misalign),
        .illegal  (align_illegal)
    );

    // Op latch: only the fields a pending load still needs.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_we      <= in_we;
            op_rd      <= in_rd;
            op_func3   <= in_func3;
            op_addr_lo <= in_addr_lo;
        end
    end

    always_comb begin
        state_nx    = state;
        tmo_cnt_nx  = tmo_cnt;
        reg_we_nx   = 1'b0;
        load_err_nx = 1'b0;
        reg_wr_nx   = RegWr;
        reg_wd_nx   = RegWd;
        case (state)
            IDLE, WRITE: begin
                if (accept) begin
                    if (in_is_load) begin
                        state_nx   = WAIT_LOAD;
                        tmo_cnt_nx = '0;
                    end else begin
                        state_nx  = WRITE;
                        reg_we_nx = in_we & (in_rd != 5'd0);
                        reg_wr_nx = in_rd;
                        reg_wd_nx = in_result;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT_LOAD: begin
                // A response in the last allowed cycle still wins over the timeout.
                if (dmem_rvalid) begin
                    state_nx = WRITE;
                    if (align_misalign | align_illegal) begin
                        load_err_nx = 1'b1;
                    end else begin
                        reg_we_nx = op_we & (op_rd != 5'd0);
                        reg_wr_nx = op_rd;
                        reg_wd_nx = align_data;
                    end
                end else if (timed_out) begin
                    state_nx    = IDLE;
                    load_err_nx = 1'b1;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tmo_cnt  <= '0;
            RegWe    <= 1'b0;
            RegWr    <= '0;
            RegWd    <= '0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nx;
            tmo_cnt  <= tmo_cnt_nx;
            RegWe    <= reg_we_nx;
            RegWr    <= reg_wr_nx;
            RegWd    <= reg_wd_nx;
            load_err <= load_err_nx;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = RegWe;
    assign fwd_rd    = RegWr;
    assign fwd_data  = RegWd;
    assign wait_load = (state == WAIT_LOAD);
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized op
// streams checked against a transaction-level load/write model.
module tb_wb_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic            in_we;
    logic            in_is_load;
    logic [4:0]      in_rd;
    logic [2:0]      in_func3;
    logic [1:0]      in_addr_lo;
    logic [XLEN-1:0] in_result;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;
    logic            RegWe;
    logic [4:0]      RegWr;
    logic [XLEN-1:0] RegWd;
    logic            load_err;
`ifdef WB_FWD_EN
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
    logic            wait_load;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(XLEN), .LOAD_TIMEOUT(255)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_we       (in_we),
        .in_is_load  (in_is_load),
        .in_rd       (in_rd),
        .in_func3    (in_func3),
        .in_addr_lo  (in_addr_lo),
        .in_result   (in_result),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .RegWe       (RegWe),
        .RegWr       (RegWr),
        .RegWd       (RegWd),
        .load_err    (load_err)
`ifdef WB_FWD_EN
        ,
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .wait_load   (wait_load)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference load result from the load-type rules, using plain arithmetic.
    function automatic void ref_load(input logic [2:0] f3, input int a, input logic [31:0] rdata,
                                     output logic [31:0] data, output bit err);
        logic [31:0] v;
        err  = 0;
        data = 0;
        case (f3)
            3'd0, 3'd4: begin
                v = (rdata >> (8 * a)) & 32'h0000_00FF;
                if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
                data = v;
            end
            3'd1, 3'd5: begin
                if (a % 2 != 0) err = 1;
                v = (rdata >> (16 * (a / 2))) & 32'h0000_FFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
                data = v;
            end
            3'd2: begin
                if (a != 0) err = 1;
                data = rdata;
            end
            default: err = 1;
        endcase
    endfunction

    task automatic expect_out(input string tag, input bit we, input logic [4:0] rd,
                              input logic [31:0] wd, input bit err);
        chk({tag, ".RegWe"}, 32'(RegWe), 32'(we));
        chk({tag, ".load_err"}, 32'(load_err), 32'(err));
        if (we) begin
            chk({tag, ".RegWr"}, 32'(RegWr), 32'(rd));
            chk({tag, ".RegWd"}, RegWd, wd);
        end
`ifdef WB_FWD_EN
        chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(we));
        if (we) begin
            chk({tag, ".fwd_rd"}, 32'(fwd_rd), 32'(rd));
            chk({tag, ".fwd_data"}, fwd_data, wd);
        end
`endif
    endtask

    // All tasks begin and end at a falling edge.
    task automatic idle(input string tag, input bit spurious);
        in_valid    = 1'b0;
        dmem_rvalid = spurious;
        dmem_rdata  = $urandom;
        @(posedge clk);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        expect_out(tag, 0, 5'd0, 32'd0, 0);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_alu(input string tag, input logic [4:0] rd, input bit we, input logic [31:0] res);
        chk({tag, ".ready_pre"}, 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_we      = we;
        in_rd      = rd;
        in_func3   = 3'($urandom);
        in_addr_lo = 2'($urandom);
        in_result  = res;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        expect_out(tag, we && (rd != 5'd0), rd, res, 0);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic do_load(input string tag, input logic [4:0] rd, input bit we, input logic [2:0] f3,
                           input logic [1:0] a, input logic [31:0] rdata, input int delay);
        logic [31:0] exp_data;
        bit          exp_err;
        ref_load(f3, int'(a), rdata, exp_data, exp_err);
        chk({tag, ".ready_pre"}, 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_we      = we;
        in_rd      = rd;
        in_func3   = f3;
        in_addr_lo = a;
        in_result  = $urandom;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < delay; i++) begin
            chk({tag, ".wait_ready"}, 32'(in_ready), 32'd0);
            expect_out({tag, ".wait"}, 0, 5'd0, 32'd0, 0);
`ifdef WB_FWD_EN
            chk({tag, ".wait_load"}, 32'(wait_load), 32'd1);
`endif
            @(posedge clk);
            @(negedge clk);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(posedge clk);
        @(negedge clk);
        dmem_rvalid = 1'b0;
        dmem_rdata  = $urandom;
        expect_out(tag, !exp_err && we && (rd != 5'd0), rd, exp_data, exp_err);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    function automatic logic [2:0] rand_f3();
        logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        if ($urandom_range(0, 9) < 8) return legal[$urandom_range(0, 4)];
        return 3'($urandom);
    endfunction

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_we       = 1'b0;
        in_is_load  = 1'b0;
        in_rd       = '0;
        in_func3    = '0;
        in_addr_lo  = '0;
        in_result   = '0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        #23;
        expect_out("reset", 0, 5'd0, 32'd0, 0);
        chk("reset.RegWr", 32'(RegWr), 32'd0);
        chk("reset.RegWd", RegWd, 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_reset", 1);

        do_alu("add", 5'd5, 1, 32'h0000_1234);
        idle("add_once", 0);

        do_load("lb", 5'd7, 1, 3'b000, 2'd3, 32'h80FF_FF00, 3);
        idle("lb_once", 0);
        do_load("lhu", 5'd8, 1, 3'b101, 2'd2, 32'hBEEF_0000, 1);
        do_load("lh", 5'd9, 1, 3'b001, 2'd2, 32'hBEEF_0000, 0);
        idle("lh_once", 0);

        do_load("lw_mis", 5'd10, 1, 3'b010, 2'd1, 32'h1234_5678, 2);
        idle("lw_mis_once", 0);

        // Load with no response: expect an abort after 255 waiting cycles.
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_we      = 1'b1;
        in_rd      = 5'd11;
        in_func3   = 3'b010;
        in_addr_lo = 2'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 255; i++) begin
            chk("tmo.wait_ready", 32'(in_ready), 32'd0);
            chk("tmo.wait_err", 32'(load_err), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        expect_out("tmo.abort", 0, 5'd0, 32'd0, 1);
        chk("tmo.in_ready", 32'(in_ready), 32'd1);
        idle("tmo_once", 0);

        do_alu("b2b1", 5'd1, 1, 32'hAAAA_0001);
        do_alu("b2b2", 5'd2, 1, 32'hBBBB_0002);
        do_alu("b2b0", 5'd0, 1, 32'hCCCC_0003);
        idle("b2b_end", 0);

        // Reset during a pending load, then a late response.
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_we      = 1'b1;
        in_rd      = 5'd12;
        in_func3   = 3'b010;
        in_addr_lo = 2'd0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_out("rst_mid", 0, 5'd0, 32'd0, 0);
        chk("rst_mid.RegWr", 32'(RegWr), 32'd0);
        chk("rst_mid.RegWd", RegWd, 32'd0);
        chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        idle("rst_late_rvalid", 1);
`ifdef WB_FWD_EN
        chk("rst_late.wait_load", 32'(wait_load), 32'd0);
`endif

        for (int n = 0; n < 200; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                do_alu("rnd_alu", 5'($urandom), $urandom_range(0, 3) != 0, $urandom);
            end else if (sel < 9) begin
                logic [2:0] f3;
                logic [1:0] a;
                f3 = rand_f3();
                a  = 2'($urandom);
                if (f3 == 3'b010 && $urandom_range(0, 3) != 0) a = 2'd0;
                do_load("rnd_load", 5'($urandom), $urandom_range(0, 3) != 0, f3, a,
                        $urandom, $urandom_range(0, 6));
            end else begin
                idle("rnd_idle", 1);
            end
        end
        idle("final", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
